// File: rtl/x25519_mult_column_engine.sv
// ---------------------------------------------------------------------------
// x25519_mult_column_engine
//
// Multi-cycle, multi-lane column engine for the X25519 field multiplier.
// Each accepted request computes LANES consecutive output columns of the
// reduced schoolbook product of two limb vectors. A product a[j]*b[c-j]
// whose limb index j exceeds the column index c has wrapped past the top
// limb, so it is scaled by FOLD (38 = 2*19 for p = 2^255 - 19, radix 2^8).
// MACS limb products are accumulated per lane per cycle, giving a latency of
// NUM_LIMBS/MACS clock edges after the request is sampled.
//
// Ports
//   clk       in   single clock
//   rst_n     in   synchronous active-low reset
//   en        in   start request, sampled only while busy = 0
//   a, b      in   operands, limb j at [j*LIMB_WIDTH +: LIMB_WIDTH]
//   i         in   first column index
//   busy      out  request in progress (registered)
//   out_valid out  one-cycle completion strobe (registered)
//   out       out  lane L holds column (i+L) mod NUM_LIMBS at
//                  [L*OUT_WIDTH +: OUT_WIDTH]; held until next completion
// ---------------------------------------------------------------------------
module x25519_mult_column_engine #(
    parameter int NUM_LIMBS  = 32,
    parameter int LIMB_WIDTH = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int FOLD       = 38,
    parameter int LANES      = 1,
    parameter int MACS       = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic [NUM_LIMBS*LIMB_WIDTH-1:0]  a,
    input  logic [NUM_LIMBS*LIMB_WIDTH-1:0]  b,
    input  logic [$clog2(NUM_LIMBS)-1:0]     i,
    output logic                             busy,
    output logic                             out_valid,
    output logic [LANES*OUT_WIDTH-1:0]       out
);

    localparam int IDXW   = $clog2(NUM_LIMBS);
    localparam int OPW    = NUM_LIMBS * LIMB_WIDTH;
    localparam int LANEW  = LANES * OUT_WIDTH;
    localparam int STEPS  = NUM_LIMBS / MACS;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [OPW-1:0]      a_q, a_d;
    logic [OPW-1:0]      b_q, b_d;
    logic [IDXW-1:0]     i_q, i_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [LANEW-1:0]    acc_q, acc_d;
    logic                busy_q, busy_d;
    logic                out_valid_q, out_valid_d;
    logic [LANEW-1:0]    out_q, out_d;

    // Products for the current step, one slot per (lane, mac) pair.
    logic [LANES*MACS*OUT_WIDTH-1:0] term_s;
    // Accumulator contents plus this step's products, per lane.
    logic [LANEW-1:0]                sum_s;

    for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
        // Column index wraps naturally because NUM_LIMBS is a power of two.
        logic [IDXW-1:0] col_s;
        assign col_s = i_q + IDXW'(gl);

        for (genvar gm = 0; gm < MACS; gm++) begin : g_mac
            logic [IDXW-1:0]       j_s;
            logic [IDXW-1:0]       bidx_s;
            logic [LIMB_WIDTH-1:0] a_limb_s;
            logic [LIMB_WIDTH-1:0] b_limb_s;
            logic [OUT_WIDTH-1:0]  prod_s;

            assign j_s      = IDXW'(32'(step_q) * MACS + gm);
            assign bidx_s   = col_s - j_s;
            assign a_limb_s = a_q[j_s * LIMB_WIDTH +: LIMB_WIDTH];
            assign b_limb_s = b_q[bidx_s * LIMB_WIDTH +: LIMB_WIDTH];
            assign prod_s   = OUT_WIDTH'(a_limb_s) * OUT_WIDTH'(b_limb_s);
            // j > c means b's index wrapped below zero: apply the fold.
            assign term_s[(gl*MACS+gm)*OUT_WIDTH +: OUT_WIDTH] =
                (j_s > col_s) ? (prod_s * OUT_WIDTH'(FOLD)) : prod_s;
        end
    end

    // Adder tree: add this step's MACS products onto each lane accumulator.
    always_comb begin
        sum_s = acc_q;
        for (int l = 0; l < LANES; l++) begin
            for (int m = 0; m < MACS; m++) begin
                sum_s[l*OUT_WIDTH +: OUT_WIDTH] = sum_s[l*OUT_WIDTH +: OUT_WIDTH]
                    + term_s[(l*MACS+m)*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    // Next-state and datapath control for the IDLE/ACCUM sequencer.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        i_d         = i_q;
        step_d      = step_q;
        acc_d       = acc_q;
        busy_d      = busy_q;
        out_valid_d = 1'b0;
        out_d       = out_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = ACCUM;
                    a_d     = a;
                    b_d     = b;
                    i_d     = i;
                    step_d  = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ACCUM: begin
                acc_d = sum_s;
                if (step_q == LAST_STEP) begin
                    state_d     = IDLE;
                    step_d      = '0;
                    out_d       = sum_s;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    step_d      = step_q + STEP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            i_q         <= '0;
            step_q      <= '0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            i_q         <= i_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule

// File: tb/tb_x25519_mult_column_engine.sv
module tb_x25519_mult_column_engine;

    localparam int LAT  = 8;
    localparam int LAT4 = 4;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [255:0] a;
    logic [255:0] b;
    logic [4:0]   i;
    logic         busy;
    logic         out_valid;
    logic [31:0]  out;

    logic         en4;
    logic [255:0] a4;
    logic [255:0] b4;
    logic [4:0]   i4;
    logic         busy4;
    logic         out_valid4;
    logic [127:0] out4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [255:0] av;
        logic [255:0] bv;
        logic [4:0]   iv;
        logic [31:0]  exp;
    } vec_t;

    vec_t vecs [36];

    x25519_mult_column_engine dut (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .i(i),
        .busy(busy), .out_valid(out_valid), .out(out)
    );

    x25519_mult_column_engine #(.LANES(4), .MACS(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .a(a4), .b(b4), .i(i4),
        .busy(busy4), .out_valid(out_valid4), .out(out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Presents a request on the default DUT; returns at the negedge after the
    // sampling edge with the inputs scrambled to prove they were captured.
    task automatic start_req(input logic [255:0] av, input logic [255:0] bv, input logic [4:0] iv);
        @(negedge clk);
        a = av; b = bv; i = iv; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        a = {8{$urandom()}};
        b = {8{$urandom()}};
        i = 5'($urandom());
    endtask

    // Counts edges until out_valid; -1 if it never comes within the budget.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int           lat;
        int           pulses;
        int           pulse_k;
        logic [31:0]  pulse_out;
        logic         busy_ok;
        logic [255:0] ones;
        logic [255:0] tv;

        ones = {256{1'b1}};
        rst_n = 1'b0; en = 1'b0; a = '0; b = '0; i = 5'd0;
        en4 = 1'b0; a4 = '0; b4 = '0; i4 = 5'd0;

        // a = 1 in limb 0, b limb j = j+1: column c is c+1.
        for (int v = 0; v < 32; v++) begin
            tv = '0;
            tv[7:0] = 8'd1;
            vecs[v].av = tv;
            for (int j = 0; j < 32; j++) tv[j*8 +: 8] = 8'(j + 1);
            vecs[v].bv  = tv;
            vecs[v].iv  = 5'(v);
            vecs[v].exp = 32'(v + 1);
        end
        // a limb31 = 1, b limb1 = 5: column 0 folds to 5*38, column 1 is 0.
        tv = '0; tv[31*8 +: 8] = 8'd1; vecs[32].av = tv; vecs[33].av = tv;
        tv = '0; tv[1*8 +: 8]  = 8'd5; vecs[32].bv = tv; vecs[33].bv = tv;
        vecs[32].iv = 5'd0;  vecs[32].exp = 32'd190;
        vecs[33].iv = 5'd1;  vecs[33].exp = 32'd0;
        // All 0xFF: 65025 * (1 + 31*38) and 65025 * 32.
        vecs[34].av = ones; vecs[34].bv = ones; vecs[34].iv = 5'd0;  vecs[34].exp = 32'h0491CE9B;
        vecs[35].av = ones; vecs[35].bv = ones; vecs[35].iv = 5'd31; vecs[35].exp = 32'h001FC020;

        repeat (3) @(negedge clk);
        check("reset busy", 128'(busy), 128'd0);
        check("reset out_valid", 128'(out_valid), 128'd0);
        check("reset out", 128'(out), 128'd0);
        check("reset out4", out4, 128'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 36; v++) begin
            start_req(vecs[v].av, vecs[v].bv, vecs[v].iv);
            check($sformatf("busy vec%0d", v), 128'(busy), 128'd1);
            wait_valid(lat);
            check($sformatf("latency vec%0d", v), 128'(lat), 128'(LAT));
            check($sformatf("out vec%0d", v), 128'(out), 128'(vecs[v].exp));
        end
        @(negedge clk);
        check("out_valid one cycle", 128'(out_valid), 128'd0);
        check("out held", 128'(out), 128'h001FC020);

        // Four lanes, eight MACs: columns 30, 31, 0, 1 of all-0xFF.
        @(negedge clk);
        a4 = ones; b4 = ones; i4 = 5'd30; en4 = 1'b1;
        @(negedge clk);
        en4 = 1'b0; a4 = '0; b4 = '0; i4 = 5'd3;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid4) begin
                lat = k;
                break;
            end
        end
        check("latency lanes4", 128'(lat), 128'(LAT4));
        check("lane0 col30", 128'(out4[31:0]),   128'h00447645);
        check("lane1 col31", 128'(out4[63:32]),  128'h001FC020);
        check("lane2 col0",  128'(out4[95:64]),  128'h0491CE9B);
        check("lane3 col1",  128'(out4[127:96]), 128'h046D1876);

        // en while busy is ignored: one pulse, original column's result.
        start_req(ones, ones, 5'd0);
        pulses = 0; pulse_k = -1; pulse_out = '0; busy_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 3) begin
                en = 1'b1; a = ones; b = ones; i = 5'd31;
            end
            if (k == 5) en = 1'b0;
            if (k < LAT && !busy) busy_ok = 1'b0;
            if (out_valid) begin
                pulses++;
                pulse_k = k;
                pulse_out = out;
            end
        end
        check("busy held while en ignored", 128'(busy_ok), 128'd1);
        check("pulses with en while busy", 128'(pulses), 128'd1);
        check("latency en while busy", 128'(pulse_k), 128'(LAT));
        check("out en while busy", 128'(pulse_out), 128'h0491CE9B);

        // en in the out_valid cycle is accepted.
        start_req(ones, ones, 5'd0);
        wait_valid(lat);
        check("first of back-to-back", 128'(out), 128'h0491CE9B);
        a = ones; b = ones; i = 5'd31; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("busy after back-to-back accept", 128'(busy), 128'd1);
        wait_valid(lat);
        check("latency back-to-back", 128'(lat), 128'(LAT));
        check("out back-to-back", 128'(out), 128'h001FC020);

        // Reset during step 5 aborts the request silently.
        start_req(ones, ones, 5'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("pulses after abort", 128'(pulses), 128'd0);
        check("out after abort", 128'(out), 128'd0);
        check("busy after abort", 128'(busy), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
